// File: rtl/pong_pkg.sv
// Shared screen geometry defaults, colour constants and the RGB colour type
// used by the pong renderer and its helpers.
package pong_pkg;

    // RGB colour packed as {R[23:16], G[15:8], B[7:0]}.
    typedef logic [23:0] rgb_t;

    // Coordinate width of every pixel / position input.
    localparam int unsigned COORD_W = 10;

    // Default screen and object geometry.
    localparam int unsigned DEF_SCREEN_W   = 640;
    localparam int unsigned DEF_SCREEN_H   = 480;
    localparam int unsigned DEF_BALL_SIZE  = 8;
    localparam int unsigned DEF_PADDLE_W   = 8;
    localparam int unsigned DEF_PADDLE_H   = 64;
    localparam int unsigned DEF_PADDLE_L_X = 16;
    localparam int unsigned DEF_PADDLE_R_X = 616;
    localparam int unsigned DEF_WALL_H     = 4;
    localparam int unsigned DEF_NET_X      = 319;
    localparam int unsigned DEF_NET_W      = 2;
    localparam int unsigned DEF_NET_DASH   = 16;

    // Default palette.
    localparam rgb_t COL_BALL   = 24'hFFFF00;
    localparam rgb_t COL_PADDLE = 24'hFFFFFF;
    localparam rgb_t COL_WALL   = 24'h0000FF;
    localparam rgb_t COL_NET    = 24'h808080;
    localparam rgb_t COL_BG     = 24'h000000;

endpackage

// File: rtl/pong_renderer_if.sv
// Pixel query bus: the current pixel, the object positions and the
// registered colour coming back from the renderer.
interface pong_renderer_if;
    import pong_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] paddleL_y;
    logic [COORD_W-1:0] paddleR_y;
    rgb_t               out_color;

    // Game / scan logic side: drives the pixel and positions.
    modport master (
        output x, y, ball_x, ball_y, paddleL_y, paddleR_y,
        input  out_color
    );

    // Renderer side.
    modport slave (
        input  x, y, ball_x, ball_y, paddleL_y, paddleR_y,
        output out_color
    );

endinterface

// File: rtl/pong_rect_hit.sv
// Combinational point-in-rectangle test. Bounds are inclusive low,
// exclusive high; upper bounds are formed at 11 bits so a rectangle near the
// top of the coordinate range never wraps onto small coordinates.
module pong_rect_hit
    import pong_pkg::*;
(
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] rx,
    input  logic [COORD_W-1:0] ry,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    // Extend to 11 bits before adding so the carry is kept.
    always_comb begin
        x_end = {1'b0, rx} + {1'b0, w};
        y_end = {1'b0, ry} + {1'b0, h};
        hit   = (px >= rx) && ({1'b0, px} < x_end) &&
                (py >= ry) && ({1'b0, py} < y_end);
    end

endmodule

// File: rtl/pong_renderer.sv
// Pong scene renderer: decides the colour of pixel (x,y) from the ball,
// paddle, wall and net geometry and registers it with one cycle of latency.
module pong_renderer
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE  = DEF_BALL_SIZE,
    parameter int unsigned PADDLE_W   = DEF_PADDLE_W,
    parameter int unsigned PADDLE_H   = DEF_PADDLE_H,
    parameter int unsigned PADDLE_L_X = DEF_PADDLE_L_X,
    parameter int unsigned PADDLE_R_X = DEF_PADDLE_R_X,
    parameter int unsigned WALL_H     = DEF_WALL_H,
    parameter int unsigned NET_X      = DEF_NET_X,
    parameter int unsigned NET_W      = DEF_NET_W,
    parameter int unsigned NET_DASH   = DEF_NET_DASH,
    parameter rgb_t        C_BALL     = COL_BALL,
    parameter rgb_t        C_PADDLE   = COL_PADDLE,
    parameter rgb_t        C_WALL     = COL_WALL,
    parameter rgb_t        C_NET      = COL_NET,
    parameter rgb_t        C_BG       = COL_BG
) (
    input  logic                   clk,
    input  logic                   rst,
    pong_renderer_if.slave         bus
);

    // 11-bit constants so every comparison is width-matched and wrap-free.
    localparam logic [COORD_W:0] SCR_W_11    = (COORD_W + 1)'(SCREEN_W);
    localparam logic [COORD_W:0] SCR_H_11    = (COORD_W + 1)'(SCREEN_H);
    localparam logic [COORD_W:0] WALL_TOP_11 = (COORD_W + 1)'(WALL_H);
    localparam logic [COORD_W:0] WALL_BOT_11 = (COORD_W + 1)'(SCREEN_H - WALL_H);
    localparam logic [COORD_W:0] NET_LO_11   = (COORD_W + 1)'(NET_X);
    localparam logic [COORD_W:0] NET_HI_11   = (COORD_W + 1)'(NET_X + NET_W);
    localparam logic [COORD_W-1:0] DASH_10   = COORD_W'(NET_DASH);

    logic               ball_hit;
    logic               pad_l_hit;
    logic               pad_r_hit;
    logic               wall_hit;
    logic               net_hit;
    logic               off_screen;
    logic [COORD_W-1:0] dash_idx;
    logic [COORD_W:0]   x_11;
    logic [COORD_W:0]   y_11;
    rgb_t               pix_color;

    pong_rect_hit u_ball_hit (
        .px  (bus.x),
        .py  (bus.y),
        .rx  (bus.ball_x),
        .ry  (bus.ball_y),
        .w   (COORD_W'(BALL_SIZE)),
        .h   (COORD_W'(BALL_SIZE)),
        .hit (ball_hit)
    );

    pong_rect_hit u_pad_l_hit (
        .px  (bus.x),
        .py  (bus.y),
        .rx  (COORD_W'(PADDLE_L_X)),
        .ry  (bus.paddleL_y),
        .w   (COORD_W'(PADDLE_W)),
        .h   (COORD_W'(PADDLE_H)),
        .hit (pad_l_hit)
    );

    pong_rect_hit u_pad_r_hit (
        .px  (bus.x),
        .py  (bus.y),
        .rx  (COORD_W'(PADDLE_R_X)),
        .ry  (bus.paddleR_y),
        .w   (COORD_W'(PADDLE_W)),
        .h   (COORD_W'(PADDLE_H)),
        .hit (pad_r_hit)
    );

    // Static scene decode and priority mux: off-screen, ball, paddles, wall, net.
    always_comb begin
        x_11       = {1'b0, bus.x};
        y_11       = {1'b0, bus.y};
        dash_idx   = bus.y / DASH_10;
        off_screen = (x_11 >= SCR_W_11) || (y_11 >= SCR_H_11);
        wall_hit   = (y_11 < WALL_TOP_11) || (y_11 >= WALL_BOT_11);
        net_hit    = (x_11 >= NET_LO_11) && (x_11 < NET_HI_11) && !dash_idx[0];

        pix_color = C_BG;
        if (off_screen) begin
            pix_color = C_BG;
        end else if (ball_hit) begin
            pix_color = C_BALL;
        end else if (pad_l_hit || pad_r_hit) begin
            pix_color = C_PADDLE;
        end else if (wall_hit) begin
            pix_color = C_WALL;
        end else if (net_hit) begin
            pix_color = C_NET;
        end
    end

    // Output register; reset forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_color <= 24'h000000;
        end else begin
            bus.out_color <= pix_color;
        end
    end

endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench for pong_renderer: directed scene checks plus
// randomized pixels compared against a plain-arithmetic scene model.
module tb_pong_renderer;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   err_cnt;

    pong_renderer_if bus ();

    pong_renderer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s got %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Scene model straight from the drawing rules, using unbounded ints.
    function automatic logic [23:0] ref_color(input int px, input int py, input int bx,
                                              input int by, input int pl, input int pr);
        if (px >= 640 || py >= 480) return 24'h000000;
        if (px >= bx && px < bx + 8 && py >= by && py < by + 8) return 24'hFFFF00;
        if (px >= 16 && px < 24 && py >= pl && py < pl + 64) return 24'hFFFFFF;
        if (px >= 616 && px < 624 && py >= pr && py < pr + 64) return 24'hFFFFFF;
        if (py < 4 || py >= 476) return 24'h0000FF;
        if (px >= 319 && px < 321 && ((py / 16) % 2) == 0) return 24'h808080;
        return 24'h000000;
    endfunction

    task automatic drive(input int px, input int py, input int bx, input int by,
                         input int pl, input int pr);
        bus.x         = 10'(px);
        bus.y         = 10'(py);
        bus.ball_x    = 10'(bx);
        bus.ball_y    = 10'(by);
        bus.paddleL_y = 10'(pl);
        bus.paddleR_y = 10'(pr);
    endtask

    // Apply a pixel, clock once and compare against a given expectation.
    task automatic apply(input string tag, input int px, input int py, input int bx,
                         input int by, input int pl, input int pr, input logic [23:0] exp);
        drive(px, py, bx, by, pl, pr);
        @(posedge clk);
        #1;
        check(tag, bus.out_color, exp);
    endtask

    function automatic int near(input int base);
        int off;
        off = int'($urandom_range(0, 13)) - 3;
        return (base + off) & 1023;
    endfunction

    initial begin
        logic [23:0] prev_exp;
        logic [23:0] exp;
        int px, py, bx, by, pl, pr;

        chk_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        drive(12, 22, 10, 20, 100, 200);
        @(posedge clk);
        #1;
        check("reset_state", bus.out_color, 24'h000000);
        @(posedge clk);
        #1;
        check("reset_hold", bus.out_color, 24'h000000);
        rst = 1'b0;

        apply("ball_basic",   12,  22,   10, 20, 100, 200, 24'hFFFF00);
        apply("bg_center",   300, 300,   10, 20, 100, 200, 24'h000000);
        apply("net_dash",    319,   8,   10, 20, 100, 200, 24'h808080);
        apply("net_gap",     319,  16,   10, 20, 100, 200, 24'h000000);
        apply("net_right",   320,  40,   10, 20, 100, 200, 24'h808080);
        apply("net_past",    321,  40,   10, 20, 100, 200, 24'h000000);
        apply("paddle_l",     20, 130,   10, 20, 100, 200, 24'hFFFFFF);
        apply("paddle_l_end", 20, 164,   10, 20, 100, 200, 24'h000000);
        apply("ball_over_pd", 20, 130,   16, 128, 100, 200, 24'hFFFF00);
        apply("paddle_r",    623, 263,   10, 20, 100, 200, 24'hFFFFFF);
        apply("paddle_r_x",  624, 230,   10, 20, 100, 200, 24'h000000);
        apply("wall_top",    100,   0,   10, 20, 100, 200, 24'h0000FF);
        apply("wall_bot",    100, 476,   10, 20, 100, 200, 24'h0000FF);
        apply("wall_bot_m1", 100, 475,   10, 20, 100, 200, 24'h000000);
        apply("offscreen_x", 700,  10,   10, 20, 100, 200, 24'h000000);
        apply("offscreen_y", 100, 480,  100, 478, 100, 200, 24'h000000);
        apply("ball_nowrap",   2,  22, 1020, 20, 100, 200, 24'h000000);
        apply("ball_x_end",   18,  22,   10, 20, 100, 200, 24'h000000);
        apply("ball_y_end",   12,  28,   10, 20, 100, 200, 24'h000000);
        apply("pad_nowrap",   20,   5,   10, 20, 1000, 200, 24'h000000);

        // Reset overrides a ball pixel, then the first edge after release renders.
        drive(12, 22, 10, 20, 100, 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_override", bus.out_color, 24'h000000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release", bus.out_color, 24'hFFFF00);

        // Randomized pixels, biased toward object edges; also confirm the
        // output holds the previous colour until the next edge.
        prev_exp = 24'hFFFF00;
        for (int i = 0; i < 400; i++) begin
            bx = int'($urandom_range(0, 1023));
            by = int'($urandom_range(0, 1023));
            pl = int'($urandom_range(0, 1023));
            pr = int'($urandom_range(0, 1023));
            case ($urandom_range(0, 4))
                0: begin px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 1023)); end
                1: begin px = near(bx);  py = near(by); end
                2: begin px = near(16);  py = near(pl + int'($urandom_range(0, 60))); end
                3: begin px = near(616); py = near(pr + int'($urandom_range(0, 60))); end
                default: begin px = near(318); py = int'($urandom_range(0, 490)); end
            endcase
            exp = ref_color(px, py, bx, by, pl, pr);
            drive(px, py, bx, by, pl, pr);
            #1;
            if (i % 4 == 0) check("rand_hold", bus.out_color, prev_exp);
            @(posedge clk);
            #1;
            check($sformatf("rand_%0d_x%0d_y%0d", i, px, py), bus.out_color, exp);
            prev_exp = exp;
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
